// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : latch_ctrl_pkg
//  Brief    : Shared types and default constants for the latch write arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package latch_ctrl_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    // Write-window sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage : latch_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin picker. Searches upward from the
//             pointer with wrap and returns the first set request.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    int k;

    // First requester at or above the pointer (modulo N_REQ) wins
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k[IW-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : latch_write_arbiter
//  Brief    : Round-robin arbitration of N_REQ writers onto one shared
//             latch bank. The latch enable is sequenced through a
//             SETUP / WRITE / HOLD window so D is stable whenever the
//             bank is transparent.
//  Revision : 1.0 - initial release
// ============================================================================
module latch_write_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_ack,
    output logic                   o_latch_en,
    output logic [WIDTH-1:0]       o_latch_d,
    output logic                   o_busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] C_LAST = IW'(N_REQ - 1);

    state_e           state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    win_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             en_q;
    logic [WIDTH-1:0] d_q;
    logic             busy_q;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_valid;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .gnt_o   (w_arb_gnt),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    assign w_sel_data = i_data[w_arb_idx*WIDTH +: WIDTH];

    // Sequencer: grant and capture in IDLE, then walk the enable window
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_arb_valid) begin
                        gnt_q   <= w_arb_gnt;
                        win_q   <= w_arb_idx;
                        d_q     <= w_sel_data;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    en_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    en_q    <= 1'b0;
                    ack_q   <= gnt_q;
                    // Next search starts just above the requester just served
                    ptr_q   <= (win_q == C_LAST) ? '0 : win_q + 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt      = gnt_q;
    assign o_ack      = ack_q;
    assign o_latch_en = en_q;
    assign o_latch_d  = d_q;
    assign o_busy     = busy_q;

endmodule : latch_write_arbiter
`default_nettype wire
